// File: rtl/nvme_tcp_uart_rx.sv
// nvme_tcp_uart_rx: 8N1 UART receiver that frames NVMe/TCP command packets
// (8-byte header + buffered payload) terminated by a line-idle gap.
module nvme_tcp_uart_rx #(
  parameter int         BAUD_DIV    = 234,
  parameter int         ADDR_W      = 5,
  parameter logic [7:0] EXP_VERSION = 8'h01,
  parameter int         IDLE_BITS   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              pkt_valid,
  output logic [2:0]        err_code,
  output logic [7:0]        opcode,
  output logic [7:0]        flags,
  output logic [7:0]        cid,
  output logic [31:0]       nsid,
  output logic [ADDR_W:0]   pay_len
);

  localparam int CW  = $clog2(BAUD_DIV);
  localparam int GAP = IDLE_BITS * BAUD_DIV;
  localparam int GW  = $clog2(GAP + 1);

  localparam logic [CW-1:0] BMAX  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BHALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  localparam logic [ADDR_W:0] PMAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_VER   = 3'd1;
  localparam logic [2:0] E_FRM   = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_OVF   = 3'd4;

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_DATA, B_STOP
  } bstate_t;

  typedef enum logic [1:0] {
    P_IDLE, P_HDR, P_PAY, P_DROP
  } pstate_t;

  bstate_t b_state, b_next;
  pstate_t p_state, p_next;

  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] b_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_vld;
  logic          frame_err;

  logic [GW-1:0]   gap_cnt;
  logic            gap_done;
  logic [2:0]      hdr_cnt;
  logic [2:0]      w_err;
  logic [7:0]      w_op;
  logic [7:0]      w_fl;
  logic [7:0]      w_cid;
  logic [31:0]     w_nsid;
  logic [ADDR_W:0] w_len;
  logic            full;

  logic [7:0] mem [2**ADDR_W];

  assign rx_s = sync[1];
  assign busy = (p_state != P_IDLE);
  assign full = (w_len == PMAX);

  always_comb begin
    b_next    = b_state;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    unique case (b_state)
      B_IDLE:  if (!rx_s) b_next = B_START;
      B_START: if (b_cnt == BHALF)
                 b_next = rx_s ? B_IDLE : B_DATA;
      B_DATA:  if (b_cnt == BMAX && bit_idx == 3'd7)
                 b_next = B_STOP;
      B_STOP:  if (b_cnt == BMAX) begin
                 b_next    = B_IDLE;
                 byte_vld  = rx_s;
                 frame_err = !rx_s;
               end
      default: b_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      b_state <= B_IDLE;
      b_cnt   <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      sync    <= {sync[0], uart_rx};
      b_state <= b_next;
      if (b_next != b_state || b_cnt == BMAX)
        b_cnt <= '0;
      else
        b_cnt <= b_cnt + 1'b1;
      if (b_state == B_START)
        bit_idx <= '0;
      if (b_state == B_DATA && b_cnt == BMAX) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Idle gap only counts between bytes; byte/frame events never coincide with it.
  assign gap_done = (p_state != P_IDLE) && (b_state == B_IDLE)
                    && (gap_cnt == GLAST);

  always_comb begin
    p_next = p_state;
    unique case (p_state)
      P_IDLE: if (byte_vld) p_next = P_HDR;
      P_HDR: begin
        if (frame_err)
          p_next = P_DROP;
        else if (byte_vld && hdr_cnt == 3'd7)
          p_next = P_PAY;
      end
      P_PAY: if (frame_err || (byte_vld && full)) p_next = P_DROP;
      default: ;
    endcase
    if (gap_done) p_next = P_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state   <= P_IDLE;
      gap_cnt   <= '0;
      hdr_cnt   <= '0;
      w_err     <= E_OK;
      w_op      <= '0;
      w_fl      <= '0;
      w_cid     <= '0;
      w_nsid    <= '0;
      w_len     <= '0;
      pkt_valid <= 1'b0;
      err_code  <= '0;
      opcode    <= '0;
      flags     <= '0;
      cid       <= '0;
      nsid      <= '0;
      pay_len   <= '0;
    end else begin
      p_state   <= p_next;
      pkt_valid <= 1'b0;
      if (byte_vld || frame_err || p_state == P_IDLE)
        gap_cnt <= '0;
      else if (b_state == B_IDLE)
        gap_cnt <= gap_cnt + 1'b1;
      if (byte_vld) begin
        unique case (p_state)
          P_IDLE: begin
            w_op    <= '0;
            w_fl    <= '0;
            w_cid   <= '0;
            w_nsid  <= '0;
            w_len   <= '0;
            hdr_cnt <= 3'd1;
            w_err   <= (rx_byte != EXP_VERSION) ? E_VER : E_OK;
          end
          P_HDR: begin
            hdr_cnt <= hdr_cnt + 1'b1;
            unique case (hdr_cnt)
              3'd1: w_op          <= rx_byte;
              3'd2: w_fl          <= rx_byte;
              3'd3: w_cid         <= rx_byte;
              3'd4: w_nsid[31:24] <= rx_byte;
              3'd5: w_nsid[23:16] <= rx_byte;
              3'd6: w_nsid[15:8]  <= rx_byte;
              3'd7: w_nsid[7:0]   <= rx_byte;
              default: ;
            endcase
          end
          P_PAY: begin
            if (full) begin
              if (w_err == E_OK) w_err <= E_OVF;
            end else begin
              w_len <= w_len + 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (frame_err && p_state != P_IDLE && w_err == E_OK)
        w_err <= E_FRM;
      if (gap_done) begin
        pkt_valid <= 1'b1;
        opcode    <= w_op;
        flags     <= w_fl;
        cid       <= w_cid;
        nsid      <= w_nsid;
        pay_len   <= w_len;
        err_code  <= (p_state == P_HDR && w_err == E_OK) ? E_SHORT : w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_vld && p_state == P_PAY && !full)
      mem[w_len[ADDR_W-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_nvme_tcp_uart_rx.sv
// tb_nvme_tcp_uart_rx: directed packets over a fast UART line with
// hand-computed header, error and payload expectations.
module tb_nvme_tcp_uart_rx;

  localparam int BD = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          busy;
  logic          pkt_valid;
  logic [2:0]    err_code;
  logic [7:0]    opcode;
  logic [7:0]    flags;
  logic [7:0]    cid;
  logic [31:0]   nsid;
  logic [AW:0]   pay_len;

  int total = 0;
  int bad = 0;
  int pv_cnt = 0;
  bit busy_seen = 0;

  nvme_tcp_uart_rx #(
    .BAUD_DIV(BD), .ADDR_W(AW),
    .EXP_VERSION(8'h01), .IDLE_BITS(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .pkt_valid(pkt_valid),
    .err_code(err_code), .opcode(opcode),
    .flags(flags), .cid(cid), .nsid(nsid),
    .pay_len(pay_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_valid) pv_cnt++;
    if (busy) busy_seen = 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    uart_rx = 1'b1;
  endtask

  task automatic send_q(input logic [7:0] q[$], input int bad_idx);
    foreach (q[i]) send_byte(q[i], i != bad_idx);
  endtask

  task automatic wait_pkt(input string tag, input int target);
    for (int i = 0; i < 1000 && pv_cnt < target; i++)
      @(negedge clk);
    check(tag, pv_cnt, target);
  endtask

  task automatic rd_check(input string tag,
                          input logic [AW-1:0] a,
                          input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  function automatic void add_str(ref logic [7:0] q[$], input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  initial begin
    logic [7:0] q[$];
    int base;

    repeat (4) @(negedge clk);
    check("rst_err", {29'd0, err_code}, 32'd0);
    check("rst_nsid", nsid, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3 * BD) @(negedge clk);

    // Packet 1: good command with "Hello NVMe/TCP!" payload
    q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    send_q(q, -1);
    check("busy_mid", {31'd0, busy}, 32'd1);
    q = {};
    add_str(q, "Hello NVMe/TCP!");
    send_q(q, -1);
    wait_pkt("p1_pv", 1);
    check("p1_err", {29'd0, err_code}, 32'd0);
    check("p1_op", {24'd0, opcode}, 32'h00);
    check("p1_cid", {24'd0, cid}, 32'h01);
    check("p1_nsid", nsid, 32'h00000001);
    check("p1_len", {26'd0, pay_len}, 32'd15);
    check("p1_busy", {31'd0, busy}, 32'd0);
    rd_check("p1_rd0", 5'd0, 8'h48);
    rd_check("p1_rd14", 5'd14, 8'h21);

    // Packet 2: wrong version keeps receiving
    q = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    add_str(q, "Hello NVMe/TCP!");
    send_q(q, -1);
    wait_pkt("p2_pv", 2);
    check("p2_err", {29'd0, err_code}, 32'd1);
    check("p2_len", {26'd0, pay_len}, 32'd15);
    check("p2_cid", {24'd0, cid}, 32'h01);

    // Packet 3: five bytes only, missing nsid bytes read as zero
    q = '{8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    send_q(q, -1);
    wait_pkt("p3_pv", 3);
    check("p3_err", {29'd0, err_code}, 32'd3);
    check("p3_len", {26'd0, pay_len}, 32'd0);
    check("p3_op", {24'd0, opcode}, 32'h0A);
    check("p3_cid", {24'd0, cid}, 32'h0C);
    check("p3_nsid", nsid, 32'h0D000000);

    // Packet 4: exactly a header
    q = '{8'h01, 8'h05, 8'h06, 8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q(q, -1);
    wait_pkt("p4_pv", 4);
    check("p4_err", {29'd0, err_code}, 32'd0);
    check("p4_len", {26'd0, pay_len}, 32'd0);
    check("p4_flags", {24'd0, flags}, 32'h06);
    check("p4_nsid", nsid, 32'hDEADBEEF);

    // Packet 5: 33 payload bytes overflow a 32-byte buffer
    q = '{8'h01, 8'h11, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int i = 0; i < 33; i++) q.push_back(8'(8'h40 + i));
    send_q(q, -1);
    wait_pkt("p5_pv", 5);
    check("p5_err", {29'd0, err_code}, 32'd4);
    check("p5_len", {26'd0, pay_len}, 32'd32);
    rd_check("p5_rd31", 5'd31, 8'h5F);
    rd_check("p5_rd0", 5'd0, 8'h40);

    // Packet 6: bad stop bit on payload byte 3
    q = '{8'h01, 8'h02, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 6; i++) q.push_back(8'(8'hA0 + i));
    send_q(q, 11);
    wait_pkt("p6_pv", 6);
    check("p6_err", {29'd0, err_code}, 32'd2);
    repeat (500) @(negedge clk);
    check("p6_once", pv_cnt, 6);

    // Short low glitch on idle line
    busy_seen = 0;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (400) @(negedge clk);
    check("gl_busy", {31'd0, busy_seen}, 32'd0);
    check("gl_pv", pv_cnt, 6);

    // Reset in the middle of the header
    q = '{8'h01, 8'h03, 8'h04};
    send_q(q, -1);
    uart_rx = 1'b0;
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rs_err", {29'd0, err_code}, 32'd0);
    check("rs_op", {24'd0, opcode}, 32'h00);
    check("rs_cid", {24'd0, cid}, 32'h00);
    check("rs_len", {26'd0, pay_len}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_rd", {24'd0, rd_data}, 32'h00);
    base = pv_cnt;
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("rs_nopv", pv_cnt, base);

    // Good packet after reset
    q = '{8'h01, 8'h07, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h01, 8'h00};
    add_str(q, "AB");
    send_q(q, -1);
    wait_pkt("p7_pv", base + 1);
    check("p7_err", {29'd0, err_code}, 32'd0);
    check("p7_op", {24'd0, opcode}, 32'h07);
    check("p7_cid", {24'd0, cid}, 32'h2A);
    check("p7_nsid", nsid, 32'h00000100);
    check("p7_len", {26'd0, pay_len}, 32'd2);
    rd_check("p7_rd1", 5'd1, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nvme_tcp_uart_rx.md
Name: nvme_tcp_uart_rx

Overview:
Receive side of the board's NVMe/TCP emulation link. Deserialises 8N1 UART bytes from uart_rx and frames them into NVMe/TCP command packets: an 8-byte header (version, opcode, flags, command id, NSID big-endian) followed by payload bytes. A packet ends when the line stays idle for a fixed gap. Parsed header fields are presented with a one-cycle valid pulse. Payload is held in an internal buffer that the command FSM reads by address after the pulse.

Parameters:
BAUD_DIV, 234, clk cycles per UART bit; must be >= 8.
ADDR_W, 5, payload buffer address width; PAYLOAD_MAX = 2**ADDR_W bytes.
EXP_VERSION, 8'h01, required value of header byte 0.
IDLE_BITS, 20, line-idle gap in bit periods that terminates a packet.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
uart_rx  in  1  serial input; idles high; asynchronous to clk.
rd_addr  in  ADDR_W  payload buffer read address.
rd_data  out  8  payload byte at rd_addr, registered, 1-cycle latency.
busy  out  1  high while a packet is being received or drained.
pkt_valid  out  1  one-cycle pulse; packet ended; fields below valid.
err_code  out  3  0 OK, 1 BAD_VERSION, 2 FRAMING, 3 SHORT, 4 OVERFLOW.
opcode  out  8  header byte 1.
flags  out  8  header byte 2.
cid  out  8  header byte 3.
nsid  out  32  header bytes 4..7; byte 4 is nsid[31:24].
pay_len  out  ADDR_W+1  payload byte count, 0..PAYLOAD_MAX.

Behaviour:
- Reset, asynchronous and active-low: all outputs 0. Synchroniser flops set to 1. Both FSMs go to idle. Counters cleared. Buffer contents are not cleared.
- Two-flop synchroniser on uart_rx. All logic uses the synchronised bit.
- Bit FSM has states B_IDLE, B_START, B_DATA, B_STOP.
  - B_IDLE: on a synchronised low, go to B_START.
  - B_START: wait BAUD_DIV/2 cycles, then resample. If high, treat as a glitch and return to B_IDLE with no byte. If low, go to B_DATA.
  - B_DATA: sample 8 bits, LSB first, each BAUD_DIV cycles after the mid-start point. Then go to B_STOP.
  - B_STOP: sample one BAUD_DIV later. If 1, issue byte_vld (internal, 1 cycle). If 0, issue frame_err (internal, 1 cycle). Return to B_IDLE on the next cycle in both cases.
- Packet FSM has states P_IDLE, P_HDR, P_PAY, P_DROP.
  - P_IDLE: the first byte_vld latches byte 0 and goes to P_HDR, with hdr_cnt=1. If byte 0 != EXP_VERSION, latch error 1 but keep receiving.
  - P_HDR: bytes 1..7 are latched into opcode, flags, cid and nsid. After byte 7, go to P_PAY with pay_len=0.
  - P_PAY: each byte is written to buf[pay_len], then pay_len increments. A byte arriving when pay_len==PAYLOAD_MAX latches error 4 and goes to P_DROP; the byte is not written.
  - frame_err in any non-idle packet state latches error 2 and goes to P_DROP. frame_err in P_IDLE is ignored.
  - Only the first error is kept; later errors do not overwrite it.
- Gap counter: clears on every byte_vld and on frame_err. While the packet FSM is not idle, it increments every cycle the bit FSM is in B_IDLE. Reaching IDLE_BITS*BAUD_DIV ends the packet.
  - End in P_HDR (fewer than 8 bytes): error 3 unless an earlier error is latched.
  - End in P_PAY or P_DROP: report the latched error, or 0 if none.
  - Exactly 8 bytes is OK with pay_len=0.
  - On the ending cycle: pkt_valid=1, err_code and the field outputs are updated, then return to P_IDLE.
- Output holding:
  - Field outputs, err_code and pay_len hold their values until the next pkt_valid.
  - Internal working registers are used during reception, so outputs do not change mid-packet.
  - On error, header fields hold whatever bytes were received; missing bytes read as 0.
- busy = (packet FSM != P_IDLE). It drops in the same cycle pkt_valid is asserted.
- Buffer:
  - Single write port (parser) and single registered read port.
  - Reading an address >= pay_len returns stale data.
  - Payload writes from the next packet overwrite the buffer. The consumer must read before the next packet's payload arrives.
- Reset mid-packet: no pkt_valid is issued. Reception restarts cleanly on the next start bit.

Test Plan:
- BAUD_DIV=16, IDLE_BITS=20. Send 01 00 00 01 00 00 00 01 "Hello NVMe/TCP!", then idle. Expect one pkt_valid with err_code=0, opcode=0x00, cid=0x01, nsid=0x00000001, pay_len=15. rd_addr 0 and 14 give 'H' and '!' one cycle later.
- Same packet with byte 0 = 0x02: expect pkt_valid with err_code=1, pay_len=15, cid=0x01.
- Send 5 bytes, then idle: expect err_code=3 and pay_len=0. Then send exactly an 8-byte header: expect err_code=0, pay_len=0.
- Header plus 33 payload bytes: expect err_code=4, pay_len=32. buf[31] holds the 32nd byte, not the 33rd.
- Force the stop bit low on payload byte 3: expect err_code=2 after the gap, and exactly one pkt_valid.
- Low glitch of 4 cycles on an idle line: no packet activity and busy stays 0. Assert rst_n low mid-header: all outputs 0, no pkt_valid. The following good packet parses OK.
